// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble datapath: default data width and nibble type.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage : nibble_pkg

// File: rtl/nibble_fifo_mem.sv
// Storage array for nibble_fifo: one synchronous write port and one
// combinational read port. Contents are not reset; the FIFO never presents
// an entry that was not written since the last reset or clear.
module nibble_fifo_mem
  import nibble_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Show-ahead read: the head entry is visible without a read strobe.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule : nibble_fifo_mem

// File: rtl/nibble_fifo.sv
// Show-ahead synchronous FIFO feeding the 4-bit buffer register stage.
// Occupancy lives in its own count register so full/empty never depend on
// pointer comparison; overflow/underflow are sticky until reset or clear.
module nibble_fifo
  import nibble_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] mem_rdata;

  // Status is derived purely from the occupancy count.
  always_comb begin
    full      = (level_q == DEPTH_L);
    empty     = (level_q == '0);
    level     = level_q;
    overflow  = overflow_q;
    underflow = underflow_q;
    rd_data   = empty ? '0 : mem_rdata;
  end

  // Accept logic: a pop frees a slot in the same cycle, so a full FIFO can
  // still take a push when it is also being popped. A pop on empty is never
  // accepted, even if a push arrives in the same cycle.
  always_comb begin
    pop_ok  = rd_en && !empty;
    push_ok = wr_en && (!full || rd_en);
  end

  // Next-state for pointers, count and sticky flags; clear overrides traffic.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        level_d = level_q + LW'(1);
      end else if (pop_ok && !push_ok) begin
        level_d = level_q - LW'(1);
      end
      if (wr_en && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  nibble_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok && !clear),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

endmodule : nibble_fifo

// File: tb/tb_nibble_fifo.sv
// Self-checking bench for nibble_fifo: a queue model tracks expected contents
// and sticky flags; popped data is compared against the queue head.
module tb_nibble_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             clear;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  nibble_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb_q [$];
  logic             m_ovf;
  logic             m_udf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    logic [WIDTH-1:0] head;
    head = (sb_q.size() == 0) ? '0 : sb_q[0];
    check_val({tag, ":level"},     32'(level),     32'(sb_q.size()));
    check_val({tag, ":full"},      32'(full),      32'(sb_q.size() == DEPTH));
    check_val({tag, ":empty"},     32'(empty),     32'(sb_q.size() == 0));
    check_val({tag, ":overflow"},  32'(overflow),  32'(m_ovf));
    check_val({tag, ":underflow"}, 32'(underflow), 32'(m_udf));
    check_val({tag, ":rd_data"},   32'(rd_data),   32'(head));
  endtask

  // One clock of traffic; the model decides acceptance from its own state.
  task automatic cycle(input string tag, input logic wr, input logic [WIDTH-1:0] wd, input logic rd);
    logic full_m, empty_m, push_m, pop_m;
    logic [WIDTH-1:0] exp_d;
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    full_m  = (sb_q.size() == DEPTH);
    empty_m = (sb_q.size() == 0);
    push_m  = wr && (!full_m || rd);
    pop_m   = rd && !empty_m;
    if (pop_m) begin
      exp_d = sb_q.pop_front();
      check_val({tag, ":pop_data"}, 32'(rd_data), 32'(exp_d));
    end
    if (push_m) sb_q.push_back(wd);
    if (wr && !push_m) m_ovf = 1'b1;
    if (rd && empty_m) m_udf = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("txn %s wr=%0b wd=%0h rd=%0b -> level=%0d rd_data=%0h ovf=%0b udf=%0b",
             tag, wr, wd, rd, level, rd_data, overflow, underflow);
    check_status(tag);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    wr_en = 1'b1;
    wr_data = 4'hE;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    $display("txn %s clear -> level=%0d", tag, level);
    check_status(tag);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    rd_en = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_status("reset");

    // Fill 1..8, then drain in order.
    for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, WIDTH'(i), 1'b0);
    check_val("full_after_8", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1);
    check_val("empty_after_drain", 32'(empty), 32'd1);

    // Full: dropped push, then push+pop at full, then drain to see B at tail.
    for (int i = 0; i < DEPTH; i++) cycle("refill", 1'b1, WIDTH'(i + 2), 1'b0);
    cycle("ovf_push", 1'b1, 4'hA, 1'b0);
    check_val("ovf_set", 32'(overflow), 32'd1);
    cycle("full_pushpop", 1'b1, 4'hB, 1'b1);
    check_val("full_pushpop_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, '0, 1'b1);

    // Empty push+pop: pop ignored, push accepted.
    do_clear("clr1");
    cycle("empty_pushpop", 1'b1, 4'h5, 1'b1);
    check_val("empty_pushpop_udf", 32'(underflow), 32'd1);
    check_val("empty_pushpop_data", 32'(rd_data), 32'h5);
    cycle("pop5", 1'b0, '0, 1'b1);

    // Wrap-around at level 3 with simultaneous push/pop.
    do_clear("clr2");
    for (int i = 0; i < 3; i++) cycle("pre", 1'b1, WIDTH'($urandom_range(0, 15)), 1'b0);
    for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, WIDTH'($urandom_range(0, 15)), 1'b1);
    for (int i = 0; i < 3; i++) cycle("wrap_drain", 1'b0, '0, 1'b1);

    // Clear mid-burst at level 5, then a push must read back.
    for (int i = 0; i < 5; i++) cycle("burst", 1'b1, WIDTH'(i + 9), 1'b0);
    cycle("udf_mark", 1'b0, '0, 1'b0);
    do_clear("clr3");
    cycle("post_clr_push", 1'b1, 4'h7, 1'b0);
    check_val("post_clr_data", 32'(rd_data), 32'h7);
    cycle("post_clr_pop", 1'b0, '0, 1'b1);

    // Async reset mid-burst at level 5 with sticky flag set.
    cycle("udf_pop", 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cycle("burst2", 1'b1, WIDTH'(i + 3), 1'b0);
    reset = 1'b1;
    sb_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    check_status("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_status("after_reset");
    cycle("post_rst_push", 1'b1, 4'hC, 1'b0);
    cycle("post_rst_pop", 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nibble_fifo
